// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: one WIDTH-bit adder shared by NREQ requesters.
// A round-robin arbiter grants one valid/ready request at a time. The
// registered sum comes back on a single response channel tagged with the
// requester id. Only one transaction is in flight at a time.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid                  [NREQ]
//   req_ready  per-requester accept, one-hot or zero (comb)  [NREQ]
//   req_a      operand A, requester i at [i*WIDTH +: WIDTH]  [NREQ*WIDTH]
//   req_b      operand B, same packing as req_a              [NREQ*WIDTH]
//   rsp_valid  response valid
//   rsp_ready  response accepted by the consumer
//   rsp_sum    (A+B) mod 2^WIDTH                             [WIDTH]
//   rsp_id     index of the granted requester                [IDW]
//   rsp_ovf    adder carry-out (only with SHARED_ADDER_OVF_EN)
//
// Build option: define SHARED_ADDER_OVF_EN to add the rsp_ovf port and the
// carry register.
module shared_adder_arbiter #(
    parameter int unsigned  WIDTH = 6,
    parameter int unsigned  NREQ  = 4,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic [IDW-1:0]        rsp_id
`ifdef SHARED_ADDER_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   grant_next;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] add_sum;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves to the requester after the winner; explicit wrap since
    // NREQ need not be a power of two.
    assign grant_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Operand mux in front of the single shared adder.
    assign op_a = req_a[32'(grant_idx) * WIDTH +: WIDTH];
    assign op_b = req_b[32'(grant_idx) * WIDTH +: WIDTH];

`ifdef SHARED_ADDER_OVF_EN
    logic [WIDTH:0] add_full;
    logic           ovf_q;
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign add_sum  = add_full[WIDTH-1:0];
`else
    assign add_sum  = op_a + op_b;
`endif

    // Next-state, grant and pointer update.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = RESP;
                    rr_ptr_d             = grant_next;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Result registers; held unchanged while the response is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum <= '0;
            rsp_id  <= '0;
`ifdef SHARED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            rsp_sum <= add_sum;
            rsp_id  <= grant_idx;
`ifdef SHARED_ADDER_OVF_EN
            ovf_q   <= add_full[WIDTH];
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);

`ifdef SHARED_ADDER_OVF_EN
    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter: a reference model predicts
// grants and results; a monitor pops expected responses as they appear.
module tb_shared_adder_arbiter;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic [IDW-1:0]        rsp_id;
`ifdef SHARED_ADDER_OVF_EN
    logic                  rsp_ovf;
`endif

    shared_adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
`ifdef SHARED_ADDER_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [IDW-1:0]   id;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr  = 0;
    bit   m_busy = 1'b0;
    int   last_grant = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: grant = first valid at or after the pointer (mod NREQ),
    // only when nothing is outstanding; one response per grant.
    task automatic model_step();
        int              g;
        int              c;
        int              s;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy));
        last_grant = g;
        if (g >= 0) begin
            s     = int'(req_a[g*WIDTH +: WIDTH]) + int'(req_b[g*WIDTH +: WIDTH]);
            e.sum = WIDTH'(s % (1 << WIDTH));
            e.id  = IDW'(g);
            e.ovf = (s >= (1 << WIDTH));
            exp_q.push_back(e);
            grant_log.push_back(g);
            m_busy = 1'b1;
            m_ptr  = (g + 1) % NREQ;
        end else if (m_busy && rsp_ready) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                       input logic [NREQ*WIDTH-1:0] b, input logic rr);
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #2;
        model_step();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 1'b0;
        m_ptr  = 0;
    endtask

    // Monitor: whenever a response is presented, compare with the queue head;
    // retire it only when the consumer accepts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(1), 32'(0));
                end else begin
                    e = exp_q[0];
                    chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    chk("rsp_id",  32'(rsp_id),  32'(e.id));
`ifdef SHARED_ADDER_OVF_EN
                    chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ*WIDTH-1:0] va, vb;
        logic [NREQ-1:0]       pv;
        logic [WIDTH-1:0]      pa[NREQ];
        logic [WIDTH-1:0]      pb[NREQ];
        logic [WIDTH-1:0]      held_sum;
        logic [IDW-1:0]        held_id;

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("reset_rsp_sum",   32'(rsp_sum),   32'(0));
        chk("reset_rsp_id",    32'(rsp_id),    32'(0));
        chk("reset_req_ready", 32'(req_ready), 32'(0));
`ifdef SHARED_ADDER_OVF_EN
        chk("reset_rsp_ovf",   32'(rsp_ovf),   32'(0));
`endif
        rst_n = 1'b1;

        // Basic: req0 3+35
        va = '0; vb = '0; va[0 +: WIDTH] = 6'd3; vb[0 +: WIDTH] = 6'd35;
        cyc(4'b0001, va, vb, 1'b1);
        chk("t1_ready", 32'(req_ready), 32'(4'b0001));
        cyc(4'b0000, va, vb, 1'b1);
        chk("t1_sum", 32'(rsp_sum), 32'(6'b100110));
        chk("t1_id",  32'(rsp_id),  32'(0));

        // Wrap: req2 60+10
        va = '0; vb = '0; va[2*WIDTH +: WIDTH] = 6'd60; vb[2*WIDTH +: WIDTH] = 6'd10;
        cyc(4'b0100, va, vb, 1'b1);
        cyc(4'b0000, va, vb, 1'b1);
        chk("t2_sum", 32'(rsp_sum), 32'(6));
        chk("t2_id",  32'(rsp_id),  32'(2));
`ifdef SHARED_ADDER_OVF_EN
        chk("t2_ovf", 32'(rsp_ovf), 32'(1));
`endif

        // Pointer skip: pointer now at 3, only req1 valid
        va = '0; vb = '0; va[1*WIDTH +: WIDTH] = 6'd7; vb[1*WIDTH +: WIDTH] = 6'd9;
        cyc(4'b0010, va, vb, 1'b1);
        chk("t6_grant", 32'(req_ready), 32'(4'b0010));
        cyc(4'b0000, va, vb, 1'b1);
        va = {6'd1, 6'd2, 6'd3, 6'd4}; vb = {6'd5, 6'd6, 6'd7, 6'd8};
        cyc(4'b1111, va, vb, 1'b1);
        chk("t6_next_ptr", 32'(req_ready), 32'(4'b0100));
        cyc(4'b0000, va, vb, 1'b1);

        // Backpressure: grant req3, hold rsp_ready low for 3 cycles
        va = {6'd50, 6'd40, 6'd30, 6'd20}; vb = {6'd33, 6'd22, 6'd11, 6'd63};
        cyc(4'b1111, va, vb, 1'b0);
        chk("t4_grant", 32'(last_grant), 32'(3));
        cyc(4'b1111, va, vb, 1'b0);
        held_sum = rsp_sum; held_id = rsp_id;
        repeat (2) begin
            cyc(4'b1111, va, vb, 1'b0);
            chk("t4_sum_stable", 32'(rsp_sum), 32'(held_sum));
            chk("t4_id_stable",  32'(rsp_id),  32'(held_id));
        end
        cyc(4'b1111, va, vb, 1'b1);
        cyc(4'b1111, va, vb, 1'b0);
        chk("t4_regrant", 32'(last_grant), 32'(0));

        // Reset while a response is pending
        cyc(4'b0000, va, vb, 1'b0);
        chk("t5_pending", 32'(rsp_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("t5_rsp_sum",   32'(rsp_sum),   32'(0));
        chk("t5_rsp_id",    32'(rsp_id),    32'(0));
`ifdef SHARED_ADDER_OVF_EN
        chk("t5_rsp_ovf",   32'(rsp_ovf),   32'(0));
`endif
        model_reset();
        cyc(4'b0000, va, vb, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1010, va, vb, 1'b1);
        chk("t5_first_grant", 32'(last_grant), 32'(1));
        cyc(4'b0000, va, vb, 1'b1);

        // Round-robin from pointer 0 with everyone valid
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        repeat (10) cyc(4'b1111, va, vb, 1'b1);
        chk("t3_count", 32'(grant_log.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size())
                chk("t3_order", 32'(grant_log[i]), 32'(i % NREQ));
        end
        cyc(4'b0000, va, vb, 1'b1);

        // Random traffic: requesters hold until granted, random backpressure
        pv = '0;
        for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; end
        repeat (300) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] || last_grant == i) begin
                    pv[i] = ($urandom_range(0, 9) < 5);
                    pa[i] = WIDTH'($urandom);
                    pb[i] = WIDTH'($urandom);
                end
                va[i*WIDTH +: WIDTH] = pa[i];
                vb[i*WIDTH +: WIDTH] = pb[i];
            end
            cyc(pv, va, vb, 1'($urandom_range(0, 1)));
        end

        repeat (3) cyc(4'b0000, va, vb, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
